// File: rtl/modexp_pkg.sv
// Shared definitions for the parametrised modular exponentiation engine.
package modexp_pkg;

  localparam int WIDTH_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REDUCE,
    ST_SCAN,
    ST_SQR,
    ST_MUL,
    ST_FIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/modmul_serial.sv
// Bit-serial interleaved modular multiplier: r = a*b mod n, one bit of a per cycle, MSB first.
module modmul_serial #(
  parameter int WIDTH = 4096,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic             mm_done
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_done;

  logic [WIDTH+1:0] w_n_ext;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH+1:0] w_s1;
  logic [WIDTH-1:0] w_s2;

  // 2r + b < 3n, so two conditional subtractions bring the sum back below n.
  always_comb begin
    w_n_ext = {2'b00, r_n};
    w_sum   = {1'b0, r_acc, 1'b0} + (r_a[WIDTH-1] ? {2'b00, r_b} : '0);
    w_s1    = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
    w_s2    = (w_s1 >= w_n_ext) ? WIDTH'(w_s1 - w_n_ext) : w_s1[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a   <= a;
        r_b   <= b;
        r_n   <= n;
        r_acc <= '0;
        r_cnt <= CNT_W'(WIDTH - 1);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_acc <= w_s2;
        r_a   <= {r_a[WIDTH-2:0], 1'b0};
        if (r_cnt == '0) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign r       = r_acc;
  assign mm_done = r_done;

endmodule

// File: rtl/modexp_param.sv
// Left-to-right square-and-multiply modular exponentiation, cypher = message^exponent mod modulus.
// Define MODEXP_CONST_TIME_EN for a data-independent go-to-done latency.
module modexp_param
  import modexp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cypher,
  output logic             done,
  output logic             busy,
  output logic             error
);

`ifdef MODEXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_msg;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_idx;
  logic             r_pend;
  logic             r_err;
  logic [WIDTH-1:0] r_cypher;
  logic             r_done;
  logic             r_busy;
  logic             r_error;

  logic             w_mm_start;
  logic [WIDTH-1:0] w_mm_a;
  logic [WIDTH-1:0] w_mm_b;
  logic [WIDTH-1:0] w_mm_r;
  logic             w_mm_done;
  logic             w_ebit;
  logic             w_last;
  logic             w_short;

  // The exponent register shifts left as the index walks down, so its MSB is e[i].
  assign w_ebit  = r_exp[WIDTH-1];
  assign w_last  = (r_idx == '0);
  assign w_short = (r_mod == '0) || (!CONST_TIME && (r_mod == WIDTH'(1)));

  modmul_serial #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_modmul (
    .clk    (clk),
    .reset  (reset),
    .start  (w_mm_start),
    .a      (w_mm_a),
    .b      (w_mm_b),
    .n      (r_mod),
    .r      (w_mm_r),
    .mm_done(w_mm_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_mm_start = 1'b0;
    w_mm_a     = r_acc;
    w_mm_b     = r_acc;
    case (r_state)
      ST_IDLE:  if (go) w_next = ST_CHECK;
      ST_CHECK: w_next = w_short ? ST_FIN : ST_REDUCE;
      ST_REDUCE: begin
        w_mm_a = r_msg;
        w_mm_b = WIDTH'(1);
        if (!r_pend)        w_mm_start = 1'b1;
        else if (w_mm_done) w_next     = ST_SCAN;
      end
      ST_SCAN: begin
        if (CONST_TIME || w_ebit) w_next = ST_SQR;
        else if (w_last)          w_next = ST_FIN;
      end
      ST_SQR: begin
        if (!r_pend) w_mm_start = 1'b1;
        else if (w_mm_done) begin
          if (CONST_TIME || w_ebit) w_next = ST_MUL;
          else if (w_last)          w_next = ST_FIN;
          else                      w_next = ST_SQR;
        end
      end
      ST_MUL: begin
        w_mm_b = r_m;
        if (!r_pend)        w_mm_start = 1'b1;
        else if (w_mm_done) w_next     = w_last ? ST_FIN : ST_SQR;
      end
      ST_FIN:  w_next = ST_DONE;
      ST_DONE: if (!go) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg    <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_err    <= 1'b0;
      r_cypher <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      // One multiply in flight at a time: pend is raised by start, dropped by mm_done.
      if (w_mm_start)     r_pend <= 1'b1;
      else if (w_mm_done) r_pend <= 1'b0;

      case (r_state)
        ST_IDLE: if (go) begin
          r_msg  <= message;
          r_exp  <= exponent;
          r_mod  <= modulus;
          r_idx  <= CNT_W'(WIDTH - 1);
          r_busy <= 1'b1;
        end
        ST_CHECK: begin
          r_acc <= w_short ? '0 : WIDTH'(1);
          r_err <= (r_mod == '0);
        end
        ST_REDUCE: if (r_pend && w_mm_done) r_m <= w_mm_r;
        ST_SCAN: if (!CONST_TIME && !w_ebit && !w_last) begin
          r_idx <= r_idx - 1'b1;
          r_exp <= {r_exp[WIDTH-2:0], 1'b0};
        end
        ST_SQR: if (r_pend && w_mm_done) begin
          r_acc <= w_mm_r;
          if (!CONST_TIME && !w_ebit && !w_last) begin
            r_idx <= r_idx - 1'b1;
            r_exp <= {r_exp[WIDTH-2:0], 1'b0};
          end
        end
        ST_MUL: if (r_pend && w_mm_done) begin
          // In constant-time mode the product for a zero bit is computed but dropped.
          if (w_ebit) r_acc <= w_mm_r;
          if (!w_last) begin
            r_idx <= r_idx - 1'b1;
            r_exp <= {r_exp[WIDTH-2:0], 1'b0};
          end
        end
        ST_FIN: begin
          r_cypher <= r_acc;
          r_error  <= r_err;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        ST_DONE: if (!go) r_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign cypher = r_cypher;
  assign done   = r_done;
  assign busy   = r_busy;
  assign error  = r_error;

endmodule
